gate_vector_checker: RTL and testbench
======================================

Name: gate_vector_checker

Overview:
- Downstream consumer of the 2-input gate-bank block.
- Accepts beats of {i[1:0], F[0:7]} over a valid/ready handshake and recomputes the expected 8 gate outputs from i.
- Counts mismatches and records the first failing beat.
- Reports pass/fail once a programmed number of vectors has been consumed.
- Gives the gate-bank exercise a clocked, self-checking stage instead of eyeballed $monitor output.

Parameters:
- NUM_VECTORS, 4: beats consumed per run; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the beat index and the error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- in_valid  in  1  beat present.
- in_ready  out  1  checker can accept a beat.
- in_i  in  2  gate-bank input pair, in_i[1] = MSB.
- in_F  in  8 ([0:7])  gate-bank outputs; bit order buf, not, and, or, nor, nand, xor, xnor.
- done  out  1  run complete; held high.
- pass  out  1  done and zero errors.
- err_count  out  CNT_W  mismatching beats this run; saturates at all-ones.
- first_err_idx  out  CNT_W  beat index (0-based) of the first mismatch.
- first_err_bits  out  8 ([0:7])  XOR of expected vs received on the first mismatch.
- vec_count  out  CNT_W  beats accepted this run.

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs are 0: in_ready, done, pass, err_count, first_err_idx, first_err_bits, vec_count.
- Expected vector, from in_i = {a,b}:
  - E[0] = a, E[1] = ~a
  - E[2] = a&b, E[3] = a|b, E[4] = ~(a|b)
  - E[5] = ~(a&b), E[6] = a^b, E[7] = ~(a^b)
- Mismatch rule: any bit of in_F differs from E. In simulation the compare uses case-inequality, so X or Z on in_F or in_i always counts as a mismatch.
- FSM states:
  - IDLE: in_ready=0. start -> RUN.
  - RUN: in_ready=1. A beat is accepted when in_valid & in_ready.
  - DONE: in_ready=0, done=1. start -> RUN.
- Entering RUN (the cycle after start): clear err_count, first_err_idx, first_err_bits, vec_count, done and pass.
- Per accepted beat, all registered, visible the next cycle:
  - vec_count increments.
  - On mismatch, err_count increments (saturating).
  - If err_count was 0, latch first_err_idx = vec_count (pre-increment value) and first_err_bits = E ^ in_F.
- Last beat: the cycle after the beat with vec_count == NUM_VECTORS-1 is accepted, the state is DONE. From that cycle on, done=1 and pass = (err_count == 0) are valid, and both counters are final.
- Latency: one cycle from acceptance to counter update. done rises one cycle after the last acceptance.
- Throughput: one beat per cycle; there are no bubbles inside RUN.
- Ignored inputs:
  - start while in RUN (no restart, no clear).
  - in_valid outside RUN (no acceptance).
- Saturation: err_count stays at all-ones once reached and never wraps.
- Reset mid-run: immediate return to IDLE with all outputs cleared. The partial run is discarded.

Optional Feature:
- Macro: GVC_ERR_BITS_EN.
- Defined:
  - Adds output port err_bits, out, 8 ([0:7]): sticky OR of (E ^ in_F) over every accepted beat this run.
  - Cleared on reset and on entry to RUN; updated with the same one-cycle latency as err_count.
  - Identifies which gate types ever failed.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Clean run, NUM_VECTORS=4: start, then beats i=00,01,10,11 with correct F (00 -> F=01001101, 11 -> F=10110001), back-to-back valid -> done=1 one cycle after the 4th beat, pass=1, err_count=0, vec_count=4.
- Single fault: same run with beat 2 (i=10) and F[2] flipped (F=10110110) -> err_count=1, first_err_idx=2, first_err_bits=00100000, pass=0; with GVC_ERR_BITS_EN, err_bits=00100000.
- Multiple faults plus backpressure-free gaps:
  - in_valid toggles 1,0,1,0,...
  - beats 1 and 3 are bad.
  - -> vec_count advances only on valid cycles, err_count=2, first_err_idx=1, done after the 4th accepted beat.
- X input: beat 0 with i=2'b0x -> counted as a mismatch, err_count=1, first_err_idx=0.
- Control corner cases:
  - start pulsed mid-RUN -> ignored; counts continue.
  - rst_n low after 2 beats -> all outputs 0 immediately and state IDLE.
  - a following start + 4 clean beats -> pass=1.
- Saturation: CNT_W=2, NUM_VECTORS=3, all beats bad -> err_count=3; reuse with start after DONE -> counters clear, second clean run gives pass=1.

Source files
------------

// File: rtl/gate_vector_checker.sv
// Self-checking consumer for the 2-input gate bank: recomputes the 8 gate outputs, counts mismatches.
// Optional sticky per-gate failure mask enabled by defining GVC_ERR_BITS_EN.
module gate_vector_checker #(
   parameter int unsigned NUM_VECTORS = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_i,
   input  logic [0:7]       in_F,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [0:7]       first_err_bits,
   output logic [CNT_W-1:0] vec_count
`ifdef GVC_ERR_BITS_EN
   ,
   output logic [0:7]       err_bits
`endif
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
   logic [0:7]       first_err_bits_q, first_err_bits_d;
   logic [CNT_W-1:0] vec_count_q, vec_count_d;
`ifdef GVC_ERR_BITS_EN
   logic [0:7]       err_bits_q, err_bits_d;
`endif

   logic             a, b;
   logic [0:7]       exp_f;
   logic [0:7]       diff;
   logic             mism;
   logic             accept;

   // Expected gate outputs and per-beat compare; !== makes X/Z on the inputs count as a failure
   always_comb begin
      a      = in_i[1];
      b      = in_i[0];
      exp_f  = {a, ~a, a & b, a | b, ~(a | b), ~(a & b), a ^ b, ~(a ^ b)};
      diff   = exp_f ^ in_F;
      mism   = (in_F !== exp_f);
      accept = in_valid && (state_q == RUN);
   end

   // Next-state and next-output logic
   always_comb begin
      state_d          = state_q;
      pass_d           = pass_q;
      err_count_d      = err_count_q;
      first_err_idx_d  = first_err_idx_q;
      first_err_bits_d = first_err_bits_q;
      vec_count_d      = vec_count_q;
`ifdef GVC_ERR_BITS_EN
      err_bits_d       = err_bits_q;
`endif

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d          = RUN;
               pass_d           = 1'b0;
               err_count_d      = '0;
               first_err_idx_d  = '0;
               first_err_bits_d = '0;
               vec_count_d      = '0;
`ifdef GVC_ERR_BITS_EN
               err_bits_d       = '0;
`endif
            end
         end
         RUN: begin
            if (accept) begin
               vec_count_d = vec_count_q + CNT_W'(1);
               if (mism) begin
                  if (err_count_q == '0) begin
                     first_err_idx_d  = vec_count_q;
                     first_err_bits_d = diff;
                  end
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + CNT_W'(1);
                  end
               end
`ifdef GVC_ERR_BITS_EN
               err_bits_d = err_bits_q | diff;
`endif
               if (vec_count_q == LAST_IDX) begin
                  state_d = DONE;
                  pass_d  = (err_count_d == '0);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d == RUN);
      done_d     = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         in_ready_q       <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
         err_count_q      <= '0;
         first_err_idx_q  <= '0;
         first_err_bits_q <= '0;
         vec_count_q      <= '0;
`ifdef GVC_ERR_BITS_EN
         err_bits_q       <= '0;
`endif
      end else begin
         state_q          <= state_d;
         in_ready_q       <= in_ready_d;
         done_q           <= done_d;
         pass_q           <= pass_d;
         err_count_q      <= err_count_d;
         first_err_idx_q  <= first_err_idx_d;
         first_err_bits_q <= first_err_bits_d;
         vec_count_q      <= vec_count_d;
`ifdef GVC_ERR_BITS_EN
         err_bits_q       <= err_bits_d;
`endif
      end
   end

   assign in_ready       = in_ready_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_count_q;
   assign first_err_idx  = first_err_idx_q;
   assign first_err_bits = first_err_bits_q;
   assign vec_count      = vec_count_q;
`ifdef GVC_ERR_BITS_EN
   assign err_bits       = err_bits_q;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: default instance plus a CNT_W=2, NUM_VECTORS=3 instance.
module tb_gate_vector_checker;

   logic clk;
   logic rst_n;

   logic       start, in_valid, in_ready;
   logic [1:0] in_i;
   logic [0:7] in_F;
   logic       done, pass;
   logic [7:0] err_count, first_err_idx, vec_count;
   logic [0:7] first_err_bits;
`ifdef GVC_ERR_BITS_EN
   logic [0:7] err_bits;
`endif

   logic       s_start, s_valid, s_ready;
   logic [1:0] s_i;
   logic [0:7] s_F;
   logic       s_done, s_pass;
   logic [1:0] s_err_count, s_first_err_idx, s_vec_count;
   logic [0:7] s_first_err_bits;
`ifdef GVC_ERR_BITS_EN
   logic [0:7] s_err_bits;
`endif

   int errors;
   int checks;

   // Hand-computed good F per i = 00, 01, 10, 11 (order buf,not,and,or,nor,nand,xor,xnor)
   logic [0:7] good_f [4];

   gate_vector_checker #(.NUM_VECTORS(4), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_i(in_i), .in_F(in_F), .done(done), .pass(pass), .err_count(err_count),
      .first_err_idx(first_err_idx), .first_err_bits(first_err_bits), .vec_count(vec_count)
`ifdef GVC_ERR_BITS_EN
      , .err_bits(err_bits)
`endif
   );

   gate_vector_checker #(.NUM_VECTORS(3), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
      .in_i(s_i), .in_F(s_F), .done(s_done), .pass(s_pass), .err_count(s_err_count),
      .first_err_idx(s_first_err_idx), .first_err_bits(s_first_err_bits), .vec_count(s_vec_count)
`ifdef GVC_ERR_BITS_EN
      , .err_bits(s_err_bits)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input logic [1:0] i, input logic [0:7] f, input logic v);
      in_i     = i;
      in_F     = f;
      in_valid = v;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic s_beat(input logic [1:0] i, input logic [0:7] f);
      s_i     = i;
      s_F     = f;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", pass); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
      checks++; if (first_err_idx !== 8'd0) begin errors++; $display("FAIL reset_first_err_idx got=%0d exp=0", first_err_idx); end
      checks++; if (first_err_bits !== 8'b0) begin errors++; $display("FAIL reset_first_err_bits got=%b exp=00000000", first_err_bits); end
      checks++; if (vec_count !== 8'd0) begin errors++; $display("FAIL reset_vec_count got=%0d exp=0", vec_count); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      // in_valid while IDLE must not be accepted
      beat(2'b00, good_f[0], 1'b1);
      checks++; if (vec_count !== 8'd0) begin errors++; $display("FAIL idle_valid_ignored got=%0d exp=0", vec_count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got=%b exp=0", in_ready); end
   endtask

   task automatic test_clean_run();
      do_start();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clean_ready_after_start got=%b exp=1", in_ready); end
      for (int k = 0; k < 3; k++) beat(2'(k), good_f[k], 1'b1);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL clean_done_early got=%b exp=0", done); end
      checks++; if (vec_count !== 8'd3) begin errors++; $display("FAIL clean_vec3 got=%0d exp=3", vec_count); end
      beat(2'b11, good_f[3], 1'b1);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL clean_done got=%b exp=1", done); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL clean_pass got=%b exp=1", pass); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clean_err_count got=%0d exp=0", err_count); end
      checks++; if (vec_count !== 8'd4) begin errors++; $display("FAIL clean_vec_count got=%0d exp=4", vec_count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clean_ready_in_done got=%b exp=0", in_ready); end
      // in_valid while DONE must not be accepted; done stays high
      beat(2'b00, 8'hFF, 1'b1);
      checks++; if (vec_count !== 8'd4) begin errors++; $display("FAIL done_valid_ignored got=%0d exp=4", vec_count); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_held got=%b exp=1", done); end
   endtask

   task automatic test_single_fault();
      do_start();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL fault_done_cleared got=%b exp=0", done); end
      checks++; if (vec_count !== 8'd0) begin errors++; $display("FAIL fault_vec_cleared got=%0d exp=0", vec_count); end
      beat(2'b00, good_f[0], 1'b1);
      beat(2'b01, good_f[1], 1'b1);
      beat(2'b10, 8'b10110110, 1'b1);
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL fault_err_latency got=%0d exp=1", err_count); end
      beat(2'b11, good_f[3], 1'b1);
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL fault_err_count got=%0d exp=1", err_count); end
      checks++; if (first_err_idx !== 8'd2) begin errors++; $display("FAIL fault_first_idx got=%0d exp=2", first_err_idx); end
      checks++; if (first_err_bits !== 8'b00100000) begin errors++; $display("FAIL fault_first_bits got=%b exp=00100000", first_err_bits); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL fault_pass got=%b exp=0", pass); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL fault_done got=%b exp=1", done); end
`ifdef GVC_ERR_BITS_EN
      checks++; if (err_bits !== 8'b00100000) begin errors++; $display("FAIL fault_err_bits got=%b exp=00100000", err_bits); end
`endif
   endtask

   task automatic test_gaps_multi_fault();
      do_start();
      beat(2'b00, good_f[0], 1'b1);
      beat(2'b11, 8'hFF, 1'b0);
      checks++; if (vec_count !== 8'd1) begin errors++; $display("FAIL gap_vec_hold got=%0d exp=1", vec_count); end
      beat(2'b01, 8'b01010111, 1'b1);
      beat(2'b11, 8'hFF, 1'b0);
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL gap_err_hold got=%0d exp=1", err_count); end
      beat(2'b10, good_f[2], 1'b1);
      beat(2'b11, 8'hFF, 1'b0);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL gap_done_early got=%b exp=0", done); end
      beat(2'b11, 8'b00110001, 1'b1);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done got=%b exp=1", done); end
      checks++; if (vec_count !== 8'd4) begin errors++; $display("FAIL gap_vec_count got=%0d exp=4", vec_count); end
      checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL gap_err_count got=%0d exp=2", err_count); end
      checks++; if (first_err_idx !== 8'd1) begin errors++; $display("FAIL gap_first_idx got=%0d exp=1", first_err_idx); end
      checks++; if (first_err_bits !== 8'b00000001) begin errors++; $display("FAIL gap_first_bits got=%b exp=00000001", first_err_bits); end
`ifdef GVC_ERR_BITS_EN
      checks++; if (err_bits !== 8'b10000001) begin errors++; $display("FAIL gap_err_bits got=%b exp=10000001", err_bits); end
`endif
   endtask

   task automatic test_x_input();
      do_start();
      // 11111111 differs from the good vector for both i=00 and i=01
      beat(2'b0x, 8'hFF, 1'b1);
      beat(2'b01, good_f[1], 1'b1);
      beat(2'b10, good_f[2], 1'b1);
      beat(2'b11, good_f[3], 1'b1);
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL x_err_count got=%0d exp=1", err_count); end
      checks++; if (first_err_idx !== 8'd0) begin errors++; $display("FAIL x_first_idx got=%0d exp=0", first_err_idx); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL x_pass got=%b exp=0", pass); end
   endtask

   task automatic test_control();
      do_start();
      beat(2'b00, good_f[0], 1'b1);
      start = 1'b1;
      beat(2'b01, good_f[1], 1'b1);
      start = 1'b0;
      checks++; if (vec_count !== 8'd2) begin errors++; $display("FAIL ctl_start_ignored got=%0d exp=2", vec_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ctl_still_run got=%b exp=1", in_ready); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (vec_count !== 8'd0) begin errors++; $display("FAIL ctl_rst_vec got=%0d exp=0", vec_count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ctl_rst_ready got=%b exp=0", in_ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL ctl_rst_done got=%b exp=0", done); end
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ctl_idle_after_rst got=%b exp=0", in_ready); end
      do_start();
      for (int k = 0; k < 4; k++) beat(2'(k), good_f[k], 1'b1);
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ctl_rerun_pass got=%b exp=1", pass); end
      checks++; if (vec_count !== 8'd4) begin errors++; $display("FAIL ctl_rerun_vec got=%0d exp=4", vec_count); end
   endtask

   task automatic test_saturation();
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int k = 0; k < 3; k++) s_beat(2'(k), ~good_f[k]);
      checks++; if (s_err_count !== 2'd3) begin errors++; $display("FAIL sat_err_count got=%0d exp=3", s_err_count); end
      checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL sat_done got=%b exp=1", s_done); end
      checks++; if (s_pass !== 1'b0) begin errors++; $display("FAIL sat_pass got=%b exp=0", s_pass); end
      checks++; if (s_first_err_bits !== 8'hFF) begin errors++; $display("FAIL sat_first_bits got=%b exp=11111111", s_first_err_bits); end
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      checks++; if (s_err_count !== 2'd0) begin errors++; $display("FAIL sat_clear_err got=%0d exp=0", s_err_count); end
      checks++; if (s_vec_count !== 2'd0) begin errors++; $display("FAIL sat_clear_vec got=%0d exp=0", s_vec_count); end
      checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL sat_clear_done got=%b exp=0", s_done); end
      for (int k = 0; k < 3; k++) s_beat(2'(k), good_f[k]);
      checks++; if (s_pass !== 1'b1) begin errors++; $display("FAIL sat_rerun_pass got=%b exp=1", s_pass); end
      checks++; if (s_vec_count !== 2'd3) begin errors++; $display("FAIL sat_rerun_vec got=%0d exp=3", s_vec_count); end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      good_f[0] = 8'b01001101;
      good_f[1] = 8'b01010110;
      good_f[2] = 8'b10010110;
      good_f[3] = 8'b10110001;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_i      = 2'b00;
      in_F      = 8'h00;
      s_start   = 1'b0;
      s_valid   = 1'b0;
      s_i       = 2'b00;
      s_F       = 8'h00;

      test_reset();
      test_clean_run();
      test_single_fault();
      test_gaps_multi_fault();
      test_x_input();
      test_control();
      test_saturation();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
